// File: rtl/fpu_multiplier_pipe.sv
// fpu_multiplier_pipe
//   Three-stage pipelined IEEE-754 multiplier. Covers binary32 and binary64
//   through EXP_W/MAN_W. Rounding is round-to-nearest-even. Subnormal inputs
//   and tiny results are flushed to signed zero.
//     Stage 1: unpack, classify and sum the exponents. Any special-value
//              result (NaN, inf, zero) is decided here and carried as an override.
//     Stage 2: (MAN_W+1)x(MAN_W+1) significand product.
//     Stage 3: normalise, round, check the range and pack into the output register.
//   Optional build macro: FPU_MUL_FLAGS_EN adds out_flags =
//   {invalid, overflow, underflow, inexact}. The packed result is the same
//   with or without the macro.
//
//   Handshake: adv = !out_valid | out_ready, and in_ready = adv. All three
//   stages shift together when adv=1 and hold when adv=0. Empty slots are not
//   squeezed out. A transfer happens on a cycle where valid and ready are both 1.
//   An input transfer and an output transfer may happen in the same cycle.
module fpu_multiplier_pipe #(
    parameter  int EXP_W = 11,
    parameter  int MAN_W = 52,
    parameter  int TAG_W = 4,
    localparam int WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef FPU_MUL_FLAGS_EN
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
`else
    output logic [TAG_W-1:0] out_tag
`endif
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int ESUM_W = EXP_W + 2;

    localparam logic signed [ESUM_W-1:0] BIAS    = ESUM_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [ESUM_W-1:0] EXP_MAX = ESUM_W'((1 << EXP_W) - 1);
    localparam logic signed [ESUM_W-1:0] ZERO_S  = '0;
    localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic adv;
    logic out_valid_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify
    // ------------------------------------------------------------------
    logic             a_sign, b_sign, sign_ab;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {a_sign, a_exp, a_frac} = in_a;
    assign {b_sign, b_exp, b_frac} = in_b;
    assign sign_ab = a_sign ^ b_sign;

    // A zero exponent field counts as zero whatever the fraction holds (flush to zero).
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_frac == '0);
    assign b_inf  = (&b_exp) && (b_frac == '0);
    assign a_nan  = (&a_exp) && (a_frac != '0);
    assign b_nan  = (&b_exp) && (b_frac != '0);

`ifdef FPU_MUL_FLAGS_EN
    logic a_snan, b_snan;
    // A signalling NaN has the top fraction bit clear.
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];
`endif

    logic                     s1_valid_d,    s1_valid_q;
    logic                     s1_sign_d,     s1_sign_q;
    logic signed [ESUM_W-1:0] s1_esum_d,     s1_esum_q;
    logic [SIG_W-1:0]         s1_sig_a_d,    s1_sig_a_q;
    logic [SIG_W-1:0]         s1_sig_b_d,    s1_sig_b_q;
    logic                     s1_spec_d,     s1_spec_q;
    logic [WIDTH-1:0]         s1_spec_res_d, s1_spec_res_q;
    logic [TAG_W-1:0]         s1_tag_d,      s1_tag_q;
`ifdef FPU_MUL_FLAGS_EN
    logic                     s1_inv_d,      s1_inv_q;
`endif

    // Stage 1 next state: exponent sum, significands with hidden bit, special override.
    always_comb begin
        s1_valid_d    = in_valid;
        s1_sign_d     = sign_ab;
        s1_esum_d     = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
        s1_sig_a_d    = {1'b1, a_frac};
        s1_sig_b_d    = {1'b1, b_frac};
        s1_tag_d      = in_tag;
        s1_spec_d     = 1'b0;
        s1_spec_res_d = '0;
`ifdef FPU_MUL_FLAGS_EN
        s1_inv_d      = 1'b0;
`endif
        // The checks run in priority order: NaN, then inf*0, then inf, then zero.
        if (a_nan || b_nan) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
`ifdef FPU_MUL_FLAGS_EN
            s1_inv_d      = a_snan || b_snan;
`endif
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
`ifdef FPU_MUL_FLAGS_EN
            s1_inv_d      = 1'b1;
`endif
        end else if (a_inf || b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sign_ab, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand multiply
    // ------------------------------------------------------------------
    logic                     s2_valid_q;
    logic                     s2_sign_q;
    logic signed [ESUM_W-1:0] s2_esum_q;
    logic [PROD_W-1:0]        s2_prod_d, s2_prod_q;
    logic                     s2_spec_q;
    logic [WIDTH-1:0]         s2_spec_res_q;
    logic [TAG_W-1:0]         s2_tag_q;
`ifdef FPU_MUL_FLAGS_EN
    logic                     s2_inv_q;
`endif

    // Stage 2 next state: full-width product of the two significands.
    always_comb begin
        s2_prod_d = {{SIG_W{1'b0}}, s1_sig_a_q} * {{SIG_W{1'b0}}, s1_sig_b_q};
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, range check, pack
    // ------------------------------------------------------------------
    logic                     norm_shift;
    logic [MAN_W:0]           sig_pre;
    logic                     g_bit, r_bit, s_bit, round_up;
    logic [MAN_W+1:0]         sig_rnd;
    logic                     rnd_carry;
    logic [MAN_W-1:0]         frac_fin;
    logic [1:0]               esum_adj;
    logic signed [ESUM_W-1:0] esum_fin;
    logic                     ovf, unf;
    logic [WIDTH-1:0]         out_result_d, out_result_q;
    logic [TAG_W-1:0]         out_tag_q;
`ifdef FPU_MUL_FLAGS_EN
    logic [3:0]               out_flags_d, out_flags_q;
`endif

    // Stage 3 next state: the product lies in [1,4). Normalise, round to nearest even, then pack.
    always_comb begin
        norm_shift = s2_prod_q[PROD_W-1];
        if (norm_shift) begin
            sig_pre = s2_prod_q[PROD_W-1:MAN_W+1];
            g_bit   = s2_prod_q[MAN_W];
            r_bit   = s2_prod_q[MAN_W-1];
            s_bit   = |s2_prod_q[MAN_W-2:0];
        end else begin
            sig_pre = s2_prod_q[PROD_W-2:MAN_W];
            g_bit   = s2_prod_q[MAN_W-1];
            r_bit   = s2_prod_q[MAN_W-2];
            s_bit   = |s2_prod_q[MAN_W-3:0];
        end

        // Round up above half. On an exact tie, round up only when the kept LSB is odd.
        round_up  = g_bit && (r_bit || s_bit || sig_pre[0]);
        sig_rnd   = {1'b0, sig_pre} + {{(MAN_W+1){1'b0}}, round_up};
        rnd_carry = sig_rnd[MAN_W+1];
        // A rounding carry-out leaves 10...0. Renormalise by one more position.
        frac_fin  = rnd_carry ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];
        esum_adj  = {1'b0, norm_shift} + {1'b0, rnd_carry};
        esum_fin  = s2_esum_q + $signed({{EXP_W{1'b0}}, esum_adj});

        ovf = (esum_fin >= EXP_MAX);
        unf = (esum_fin <= ZERO_S);

        out_result_d = {s2_sign_q, esum_fin[EXP_W-1:0], frac_fin};
        if (s2_spec_q) begin
            out_result_d = s2_spec_res_q;
        end else if (ovf) begin
            out_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            out_result_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end

`ifdef FPU_MUL_FLAGS_EN
        out_flags_d = {3'b000, g_bit || r_bit || s_bit};
        if (s2_spec_q) begin
            out_flags_d = {s2_inv_q, 3'b000};
        end else if (ovf) begin
            out_flags_d = 4'b0101;
        end else if (unf) begin
            out_flags_d = 4'b0011;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    // Reset clears the valid bits and the output registers, which discards
    // every operation in flight. Otherwise all stages shift together on adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
`ifdef FPU_MUL_FLAGS_EN
            out_flags_q  <= '0;
`endif
        end else if (adv) begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_esum_q     <= s1_esum_d;
            s1_sig_a_q    <= s1_sig_a_d;
            s1_sig_b_q    <= s1_sig_b_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_res_q <= s1_spec_res_d;
            s1_tag_q      <= s1_tag_d;

            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s1_sign_q;
            s2_esum_q     <= s1_esum_q;
            s2_prod_q     <= s2_prod_d;
            s2_spec_q     <= s1_spec_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_tag_q      <= s1_tag_q;

            out_valid_q   <= s2_valid_q;
            out_result_q  <= out_result_d;
            out_tag_q     <= s2_tag_q;
`ifdef FPU_MUL_FLAGS_EN
            s1_inv_q      <= s1_inv_d;
            s2_inv_q      <= s1_inv_q;
            out_flags_q   <= out_flags_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
`ifdef FPU_MUL_FLAGS_EN
    assign out_flags  = out_flags_q;
`endif

endmodule

// File: tb/tb_fpu_multiplier_pipe.sv
// tb_fpu_multiplier_pipe
//   Bench for the binary64 build of fpu_multiplier_pipe. It drives directed
//   vectors, random operands under random backpressure, a stall and a reset
//   with operations in flight. Expected results come from a reference that
//   works on real numbers, with special values and flush-to-zero handled by
//   explicit rules. out_flags is compared only when FPU_MUL_FLAGS_EN is defined.
module tb_fpu_multiplier_pipe;

    localparam int EXP_W = 11;
    localparam int MAN_W = 52;
    localparam int TAG_W = 4;
    localparam int WIDTH = 64;
    localparam int REC_W = 4 + TAG_W + WIDTH;   // {flags, tag, result}
    localparam logic [63:0] QNAN64 = 64'h7FF8000000000000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef FPU_MUL_FLAGS_EN
    logic [3:0]       out_flags;
`endif

    fpu_multiplier_pipe #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W),
        .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
`ifdef FPU_MUL_FLAGS_EN
        .out_tag   (out_tag),
        .out_flags (out_flags)
`else
        .out_tag   (out_tag)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [REC_W-1:0] exp_q[$];
    int               cyc_q[$];
    int               cyc = 0;
    bit               check_lat = 1'b0;
    bit               rand_ready = 1'b0;
    bit               in_fired;
    logic [REC_W-1:0] pend_rec;

    task automatic check_val(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {flags[3:0], result[63:0]}. Finite normal operands are
    // multiplied as reals, which rounds to nearest even. A subnormal or zero
    // real result is flushed to signed zero.
    function automatic logic [67:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic         sa, sb, s;
        logic [10:0]  ea, eb;
        logic [51:0]  fa, fb;
        logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        real          r;
        logic [63:0]  rb;
        logic [105:0] p;
        logic         inexact;
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        s      = sa ^ sb;
        a_nan  = (ea == 11'h7FF) && (fa != 52'h0);
        b_nan  = (eb == 11'h7FF) && (fb != 52'h0);
        a_snan = a_nan && !fa[51];
        b_snan = b_nan && !fb[51];
        a_inf  = (ea == 11'h7FF) && (fa == 52'h0);
        b_inf  = (eb == 11'h7FF) && (fb == 52'h0);
        a_zero = (ea == 11'h0);
        b_zero = (eb == 11'h0);
        if (a_nan || b_nan)                         return {a_snan || b_snan, 3'b000, QNAN64};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, QNAN64};
        if (a_inf || b_inf)                         return {4'b0000, s, 11'h7FF, 52'h0};
        if (a_zero || b_zero)                       return {4'b0000, s, 63'h0};
        r  = $bitstoreal(a) * $bitstoreal(b);
        rb = $realtobits(r);
        // Exact iff the integer significand product fits in 53 significant bits.
        p  = {53'h0, 1'b1, fa} * {53'h0, 1'b1, fb};
        inexact = p[105] ? (p[52:0] != 53'h0) : (p[51:0] != 52'h0);
        if (rb[62:52] == 11'h7FF) return {4'b0101, s, 11'h7FF, 52'h0};
        if (rb[62:52] == 11'h000) return {4'b0011, s, 63'h0};
        return {3'b000, inexact, rb};
    endfunction

    // Random operand from a mix of special and normal encodings.
    function automatic logic [63:0] rand_op();
        logic        s;
        logic [10:0] e;
        logic [51:0] f;
        s = 1'($urandom_range(0, 1));
        f = {20'($urandom_range(0, 32'hFFFFF)), $urandom};
        case ($urandom_range(0, 15))
            0:       return {s, 63'h0};
            1:       return {s, 11'h0, f | 52'h1};
            2:       return {s, 11'h7FF, 52'h0};
            3:       return {s, 11'h7FF, 1'b1, f[50:0]};
            4:       return {s, 11'h7FF, 1'b0, f[50:1], 1'b1};
            5:       e = 11'(2046 - $urandom_range(0, 60));
            6:       e = 11'($urandom_range(1, 60));
            7:       e = 11'($urandom_range(990, 1056));
            8: begin
                e = 11'($urandom_range(1000, 1046));
                f = {f[51:44], 44'h0};
            end
            default: e = 11'($urandom_range(1, 2046));
        endcase
        return {s, e, f};
    endfunction

    // ---------------- per-cycle driver / monitor ----------------
    // Call at a falling edge with the inputs already set. It samples 1 unit
    // later, runs the scoreboard, then moves on to the next falling edge.
    task automatic cycle();
        logic [REC_W-1:0] rec;
        int               c0;
        if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
        #1;
        check_val("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
        in_fired = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 128'(out_valid), 128'(0));
            end else begin
                rec = exp_q.pop_front();
                c0  = cyc_q.pop_front();
                check_val("result", 128'(out_result), 128'(rec[63:0]));
                check_val("tag", 128'(out_tag), 128'(rec[67:64]));
`ifdef FPU_MUL_FLAGS_EN
                check_val("flags", 128'(out_flags), 128'(rec[71:68]));
`endif
                if (check_lat) check_val("latency", 128'(cyc - c0), 128'(3));
            end
        end
        if (in_fired) begin
            exp_q.push_back(pend_rec);
            cyc_q.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                        input logic [REC_W-1:0] rec);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        pend_rec = rec;
        do begin
            cycle();
            guard++;
        end while (!in_fired && guard < 200);
        if (!in_fired) check_val("send_timeout", 128'(in_fired), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        logic [67:0] m;
        m = ref_mul(a, b);
        send(a, b, tag, {m[67:64], tag, m[63:0]});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 400) begin
            cycle();
            guard++;
        end
        if (exp_q.size() > 0) begin
            check_val("drain_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_out_result", 128'(out_result), 128'(0));
        check_val("rst_out_tag", 128'(out_tag), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back with out_ready held high.
        out_ready = 1'b1;
        check_lat = 1'b1;
        send(64'h3FF8000000000000, 64'h4000000000000000, 4'd1, {4'h0, 4'd1, 64'h4008000000000000});
        send(64'h3FF0000000000001, 64'h3FF0000000000001, 4'd2, {4'h1, 4'd2, 64'h3FF0000000000002});
        send(64'h3FF0000000000001, 64'h3FF8000000000000, 4'd3, {4'h1, 4'd3, 64'h3FF8000000000002});
        send(64'h7FF0000000000000, 64'h0000000000000000, 4'd4, {4'h8, 4'd4, 64'h7FF8000000000000});
        send(64'h7FE0000000000000, 64'h4000000000000000, 4'd5, {4'h5, 4'd5, 64'h7FF0000000000000});
        send(64'h0010000000000000, 64'h0010000000000000, 4'd6, {4'h3, 4'd6, 64'h0000000000000000});
        send(64'hC000000000000000, 64'h7FF0000000000000, 4'd7, {4'h0, 4'd7, 64'hFFF0000000000000});
        send(64'h8000000000000000, 64'h3FF0000000000000, 4'd8, {4'h0, 4'd8, 64'h8000000000000000});
        drain();

        // Stall: with out_ready low, three ops fill the pipe and in_ready falls.
        send_model(rand_op(), rand_op(), 4'd10);
        out_ready = 1'b0;
        send_model(rand_op(), rand_op(), 4'd11);
        send_model(rand_op(), rand_op(), 4'd12);
        check_lat = 1'b0;
        idle(4);
        out_ready = 1'b1;
        drain();

        // 8 ops back to back, tags 0..7, under random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_model(rand_op(), rand_op(), 4'(i));
        drain();

        // Longer random run with random input gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_model(rand_op(), rand_op(), 4'(i));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Reset with three ops in flight.
        check_lat = 1'b1;
        send_model(rand_op(), rand_op(), 4'd1);
        send_model(rand_op(), rand_op(), 4'd2);
        send_model(rand_op(), rand_op(), 4'd3);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("reset_flush_valid", 128'(out_valid), 128'(0));
        check_val("reset_flush_result", 128'(out_result), 128'(0));
        exp_q.delete();
        cyc_q.delete();
        rst = 1'b0;
        @(negedge clk);
        idle(6);
        send(64'h3FF8000000000000, 64'h4000000000000000, 4'd9, {4'h0, 4'd9, 64'h4008000000000000});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
